// File: rtl/data_cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back data cache.
// Field extractors take widths as arguments so any legal geometry can reuse them.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WB,
    ALLOC,
    RESP
  } state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_SETS);
  localparam int DEF_TAG_W      = 30 - DEF_OFF_W - DEF_IDX_W;

  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] get_offset(input logic [31:0] addr, input int off_w);
    return addr_field(addr, 2, off_w);
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int off_w, input int idx_w);
    return addr_field(addr, 2 + off_w, idx_w);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int off_w, input int idx_w);
    return addr_field(addr, 2 + off_w + idx_w, 30 - off_w - idx_w);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU data-port bundle: valid/ready request channel plus a one-cycle response pulse.
// The CPU side uses master, the cache uses slave.
interface data_cache_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;

  modport master (
    output req_valid, req_addr, req_write, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_hit
  );
endinterface

// File: rtl/cache_backing_mem.sv
// Line-wide backing store with a MEM_LATENCY-cycle transfer timer; done pulses on the last cycle.
// Writes land only on that last cycle so an aborted transfer never modifies memory.
module cache_backing_mem #(
  parameter int LINE_WORDS      = 4,
  parameter int MEM_LATENCY     = 4,
  parameter int MEM_DEPTH_WORDS = 16384,
  parameter int LINE_W          = 28
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       active,
  input  logic                       we,
  input  logic [LINE_W-1:0]          line_addr,
  input  logic [LINE_WORDS-1:0][31:0] wline,
  output logic [LINE_WORDS-1:0][31:0] rline,
  output logic                       done
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int AW    = $clog2(MEM_DEPTH_WORDS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [31:0]      mem [MEM_DEPTH_WORDS];
  logic [CNT_W-1:0] lat_cnt;
  logic [31:0]      base_w;

  assign base_w = 32'(line_addr) << OFF_W;
  assign done   = active && (lat_cnt == CNT_W'(MEM_LATENCY - 1));

  always_comb begin
    rline = '0;
    for (int i = 0; i < LINE_WORDS; i++) rline[i] = mem[AW'(base_w + 32'(i))];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lat_cnt <= '0;
    else if (done)   lat_cnt <= '0;
    else if (active) lat_cnt <= lat_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (done && we) begin
      for (int i = 0; i < LINE_WORDS; i++) mem[AW'(base_w + 32'(i))] <= wline[i];
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache: hit resp 2 cycles, miss adds one or two line transfers.
// One request in flight; req_ready is high only in IDLE, so the CPU stalls for the whole miss.
module data_cache
  import cache_pkg::*;
#(
  parameter int LINE_WORDS      = DEF_LINE_WORDS,
  parameter int NUM_SETS        = DEF_NUM_SETS,
  parameter int MEM_LATENCY     = 4,
  parameter int MEM_DEPTH_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  data_cache_if.slave bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int LINE_W = TAG_W + IDX_W;

  state_t state, state_nxt;

  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          write_q, replay_q, hit_q;
  logic [NUM_SETS-1:0]        valid_q, dirty_q;
  logic [TAG_W-1:0]           tag_arr  [NUM_SETS];
  logic [LINE_WORDS-1:0][31:0] data_arr [NUM_SETS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;

  logic                        mem_active, mem_we, mem_done;
  logic [LINE_W-1:0]           mem_line;
  logic [LINE_WORDS-1:0][31:0] mem_rline;

  assign off = OFF_W'(get_offset(addr_q, OFF_W));
  assign idx = IDX_W'(get_index(addr_q, OFF_W, IDX_W));
  assign tag = TAG_W'(get_tag(addr_q, OFF_W, IDX_W));
  assign hit = valid_q[idx] && (tag_arr[idx] == tag);

  // WB targets the victim's line, ALLOC the requested one.
  assign mem_active = (state == WB) || (state == ALLOC);
  assign mem_we     = (state == WB);
  assign mem_line   = (state == WB) ? {tag_arr[idx], idx} : {tag, idx};

  cache_backing_mem #(
    .LINE_WORDS     (LINE_WORDS),
    .MEM_LATENCY    (MEM_LATENCY),
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS),
    .LINE_W         (LINE_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .active   (mem_active),
    .we       (mem_we),
    .line_addr(mem_line),
    .wline    (data_arr[idx]),
    .rline    (mem_rline),
    .done     (mem_done)
  );

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    unique case (state)
      IDLE:    if (bus.req_valid) state_nxt = CHECK;
      CHECK:   state_nxt = hit ? RESP : (dirty_q[idx] ? WB : ALLOC);
      WB:      if (mem_done) state_nxt = ALLOC;
      ALLOC:   if (mem_done) state_nxt = CHECK;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_hit   = hit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      replay_q <= 1'b0;
      hit_q    <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: replay_q <= 1'b0;
        CHECK: begin
          // Only the first lookup of a request is statistically interesting.
          if (!replay_q) begin
            hit_q <= hit;
            if (hit) hit_cnt  <= hit_cnt + 1'b1;
            else     miss_cnt <= miss_cnt + 1'b1;
          end
          if (hit) begin
            rdata_q <= write_q ? wdata_q : data_arr[idx][off];
            if (write_q) dirty_q[idx] <= 1'b1;
          end
        end
        WB: if (mem_done) dirty_q[idx] <= 1'b0;
        ALLOC: if (mem_done) begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          replay_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      addr_q  <= bus.req_addr;
      write_q <= bus.req_write;
      wdata_q <= bus.req_wdata;
    end
    if (state == CHECK && hit && write_q) data_arr[idx][off] <= wdata_q;
    if (state == ALLOC && mem_done) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= mem_rline;
    end
  end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache that is the responder on the CPU data-memory port. It accepts one load/store request at a time through a valid/ready handshake and returns the result with a one-cycle response pulse. Misses are served from an internal latency-modelled backing memory. It replaces the single-cycle DataMemory behind the pipelined CPU's MEM stage and stalls that stage through `req_ready`.

## Interface
- LINE_WORDS, 4: 32-bit words per line (power of 2)
- NUM_SETS, 16: lines in the cache (power of 2)
- MEM_LATENCY, 4: backing-memory cycles per line transfer (≥1)
- MEM_DEPTH_WORDS, 16384: backing memory size in words (power of 2)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  cache can accept; high only in IDLE
- req_addr  in  32  byte address; bits [1:0] ignored
- req_write  in  1  1 = store, 0 = load
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse: the request has completed
- resp_rdata  out  32  load data; echoes the store data on a store
- resp_hit  out  1  the first lookup for this request hit; valid with resp_valid
- hit_cnt  out  32  first-lookup hits since reset; wraps at 2^32
- miss_cnt  out  32  first-lookup misses since reset; wraps at 2^32

## Operation
- Address split with the defaults:
  - offset = addr[3:2]
  - index = addr[7:4]
  - tag = addr[31:8]
  - widths are derived from the parameters
- Backing word address = addr[31:2] mod MEM_DEPTH_WORDS.
- FSM states: IDLE, CHECK, WB, ALLOC, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid is high at an edge, latch addr/write/wdata and go to CHECK.
- CHECK, hit (valid && tag match):
  - a load reads the word
  - a store writes the word and sets dirty
  - go to RESP
- CHECK, miss:
  - victim dirty: go to WB
  - victim clean: go to ALLOC
- WB:
  - Count MEM_LATENCY cycles.
  - On the last cycle, write the whole victim line to backing memory at {victim tag, index} and clear dirty.
  - Go to ALLOC.
- ALLOC:
  - Count MEM_LATENCY cycles.
  - On the last cycle, fill the whole line from backing memory and set valid=1, tag=new tag, dirty=0.
  - Return to CHECK (replay), which then always hits.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Go to IDLE.
- Counters:
  - hit_cnt or miss_cnt increments only on the first CHECK of a request, never on the replay.
  - resp_hit reports the same first-lookup outcome.
- Reset:
  - Asynchronously forces: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_hit=0, counters=0, all valid and dirty bits=0, latency counter=0.
  - Tag/data arrays and backing memory are not cleared.
- Reset mid-operation: the in-flight request is dropped with no response. Backing memory is untouched, because WB writes only on its final cycle.

## Timing
- Request accepted at edge E0.
- resp_valid is sampled high at:
  - hit: E0+2
  - clean miss: E0+MEM_LATENCY+3
  - dirty miss: E0+2·MEM_LATENCY+3
- req_ready is low from the cycle after acceptance until the cycle after RESP.
- Maximum hit throughput is one request per 3 cycles.
- req_* are sampled only at the accepting edge; later changes are ignored.
- resp_rdata holds its value until the next RESP.

## Structure
- `cache_pkg`:
  - state enum
  - localparams for offset/index/tag widths, derived via $clog2
  - address-field extract functions
- Sub-module `cache_backing_mem`: word array, line read/write ports, MEM_LATENCY counter and a done strobe.
- FSM, tag/valid/dirty/data arrays and counters stay in `data_cache`.

## Test plan
- Preload backing word 0x10 = 0x11111111; after reset, load 0x40 -> resp at E0+7, rdata 0x11111111, resp_hit=0, miss_cnt=1.
- Then load 0x44 (preloaded 0x22222222) -> resp at E0+2, rdata 0x22222222, resp_hit=1, hit_cnt=1.
- Store 0xDEADBEEF to 0x40 (hit), then load 0x1040 -> resp at E0+11, and backing word 0x10 reads 0xDEADBEEF.
- req_valid held high through a miss and three following hits -> exactly one acceptance per IDLE cycle, with responses in issue order.
- Assert reset during WB -> resp_valid drops at once, no response, backing memory unchanged, a reload of 0x40 misses, counters read 0.
- MEM_LATENCY=1 build: clean miss resp at E0+4, dirty miss resp at E0+5.
